matrix_alloc_ctrl: RTL and testbench

MATRIX_ALLOC_CTRL -- requirements
Module: matrix_alloc_ctrl

---
 rtl/matrix_alloc_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_matrix_alloc_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alloc_ctrl.sv
// Matrix-memory allocator: maps (rows, cols, slot) to a fixed base address,
// tracks committed slots per dimension class and answers registered queries.
module matrix_alloc_ctrl #(
  parameter int MAX_DIM = 5,
  parameter int SLOTS   = 2,
  parameter int ADDR_W  = 9,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  input  logic [31:0]       alloc_m,
  input  logic [31:0]       alloc_n,
  input  logic              commit,
  input  logic              abort,
  output logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_base,
  output logic [SLOT_W-1:0] alloc_slot,
  output logic              alloc_err,
  output logic              busy,
  input  logic [2:0]        q_m,
  input  logic [2:0]        q_n,
  input  logic [SLOT_W-1:0] q_slot,
  output logic [ADDR_W-1:0] q_base,
  output logic              q_valid,
  output logic [SLOT_W:0]   q_count
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int NCLS  = MAX_DIM * MAX_DIM;
  localparam int CLS_W = (NCLS > 1) ? $clog2(NCLS) : 1;
  localparam int T_MAX = MAX_DIM * (MAX_DIM + 1) / 2;

  // The fixed layout must fit every class and slot in the address space.
  if (SLOTS * T_MAX * T_MAX > (1 << ADDR_W)) begin : g_size_check
    $error("matrix_alloc_ctrl: SLOTS*T(MAX_DIM)^2 exceeds 2^ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    GRANT,
    BUSY,
    ERR_HOLD
  } state_t;

  function automatic logic [ADDR_W-1:0] base_of(input logic [31:0] m,
                                                 input logic [31:0] n,
                                                 input logic [31:0] s);
    logic [31:0] tm, tn, acc;
    tm  = ((m - 32'd1) * m) >> 1;
    tn  = ((n - 32'd1) * n) >> 1;
    acc = 32'(SLOTS) * (tm * 32'(T_MAX) + m * tn) + s * m * n;
    return acc[ADDR_W-1:0];
  endfunction

  function automatic logic [CLS_W-1:0] cls_of(input logic [31:0] m,
                                              input logic [31:0] n);
    logic [31:0] idx;
    idx = (m - 32'd1) * 32'(MAX_DIM) + (n - 32'd1);
    return idx[CLS_W-1:0];
  endfunction

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  cur_m, cur_n;
  logic [SLOT_W-1:0] cur_slot, calc_slot, ptr_inc;
  logic [CLS_W-1:0]  cur_cls, q_cls;
  logic [SLOTS-1:0]  valid [NCLS];
  logic [SLOT_W-1:0] wr_ptr [NCLS];
  logic              dims_ok, latch_en, clr_en, set_en, err_nxt, found;
  logic              q_ok, q_valid_nxt;
  logic [SLOTS-1:0]  q_row;
  logic [SLOT_W:0]   q_cnt_nxt;
  logic [ADDR_W-1:0] q_base_nxt;

  assign dims_ok = (alloc_m != 32'd0) && (alloc_m <= 32'(MAX_DIM)) &&
                   (alloc_n != 32'd0) && (alloc_n <= 32'(MAX_DIM));
  assign cur_cls = cls_of(32'(cur_m), 32'(cur_n));
  assign ptr_inc = (32'(cur_slot) == 32'(SLOTS - 1)) ? '0 : cur_slot + 1'b1;

  assign alloc_ready = (state == GRANT);
  assign busy        = (state == GRANT) || (state == BUSY);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    calc_slot = wr_ptr[cur_cls];
    found     = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!found && !valid[cur_cls][s]) begin
        calc_slot = SLOT_W'(s);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    clr_en    = 1'b0;
    set_en    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (alloc_req) begin
          if (dims_ok) begin
            latch_en  = 1'b1;
            state_nxt = CALC;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERR_HOLD;
          end
        end
      end
      CALC: begin
        clr_en    = 1'b1;
        state_nxt = GRANT;
      end
      GRANT: state_nxt = BUSY;
      BUSY: begin
        // abort outranks commit, which outranks a follow-on request
        if (abort) begin
          state_nxt = IDLE;
        end else if (commit) begin
          set_en    = 1'b1;
          state_nxt = IDLE;
        end else if (alloc_req) begin
          set_en = 1'b1;
          if (dims_ok) begin
            latch_en  = 1'b1;
            state_nxt = CALC;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERR_HOLD;
          end
        end
      end
      ERR_HOLD: if (!alloc_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Queries see this cycle's pending clear/set so a slot cleared in CALC
  // reads invalid on the very next cycle.
  always_comb begin
    q_ok  = (q_m != 3'd0) && (32'(q_m) <= 32'(MAX_DIM)) &&
            (q_n != 3'd0) && (32'(q_n) <= 32'(MAX_DIM)) &&
            (32'(q_slot) < 32'(SLOTS));
    q_cls = cls_of(32'(q_m), 32'(q_n));
    q_row = '0;
    if (q_ok) begin
      q_row = valid[q_cls];
      if (clr_en && (cur_cls == q_cls)) q_row[calc_slot] = 1'b0;
      if (set_en && (cur_cls == q_cls)) q_row[cur_slot] = 1'b1;
    end
    q_cnt_nxt = '0;
    for (int s = 0; s < SLOTS; s++) begin
      q_cnt_nxt = q_cnt_nxt + {{SLOT_W{1'b0}}, q_row[s]};
    end
    q_valid_nxt = q_ok && q_row[q_slot];
    q_base_nxt  = q_ok ? base_of(32'(q_m), 32'(q_n), 32'(q_slot)) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_m      <= '0;
      cur_n      <= '0;
      cur_slot   <= '0;
      alloc_base <= '0;
      alloc_slot <= '0;
      alloc_err  <= 1'b0;
      q_base     <= '0;
      q_valid    <= 1'b0;
      q_count    <= '0;
      // NOTE: the valid/pointer arrays are control state, not data storage,
      // so they are reset; an interrupted slot is therefore left invalid.
      for (int c = 0; c < NCLS; c++) begin
        valid[c]  <= '0;
        wr_ptr[c] <= '0;
      end
    end else begin
      state     <= state_nxt;
      alloc_err <= err_nxt;
      if (latch_en) begin
        cur_m <= alloc_m[DIM_W-1:0];
        cur_n <= alloc_n[DIM_W-1:0];
      end
      if (clr_en) begin
        valid[cur_cls][calc_slot] <= 1'b0;
        cur_slot   <= calc_slot;
        alloc_slot <= calc_slot;
        alloc_base <= base_of(32'(cur_m), 32'(cur_n), 32'(calc_slot));
      end
      if (set_en) begin
        valid[cur_cls][cur_slot] <= 1'b1;
        wr_ptr[cur_cls]          <= ptr_inc;
      end
      q_base  <= q_base_nxt;
      q_valid <= q_valid_nxt;
      q_count <= q_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_matrix_alloc_ctrl.sv
// Scoreboard bench for matrix_alloc_ctrl: directed scenarios then random
// traffic, checked against an array-based model of the allocation rules.
module tb_matrix_alloc_ctrl;

  localparam int MAX_DIM = 5;
  localparam int SLOTS   = 2;
  localparam int ADDR_W  = 9;
  localparam int SLOT_W  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alloc_req, commit, abort;
  logic [31:0]       alloc_m, alloc_n;
  logic              alloc_ready, alloc_err, busy, q_valid;
  logic [ADDR_W-1:0] alloc_base, q_base;
  logic [SLOT_W-1:0] alloc_slot, q_slot;
  logic [SLOT_W:0]   q_count;
  logic [2:0]        q_m, q_n;

  always #5 clk = ~clk;

  matrix_alloc_ctrl #(.MAX_DIM(MAX_DIM), .SLOTS(SLOTS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .commit(commit), .abort(abort),
    .alloc_ready(alloc_ready), .alloc_base(alloc_base), .alloc_slot(alloc_slot),
    .alloc_err(alloc_err), .busy(busy),
    .q_m(q_m), .q_n(q_n), .q_slot(q_slot),
    .q_base(q_base), .q_valid(q_valid), .q_count(q_count)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Reference model: committed-slot flags and victim pointer per class.
  bit mvalid [1:MAX_DIM][1:MAX_DIM][SLOTS];
  int mptr   [1:MAX_DIM][1:MAX_DIM];
  bit in_busy;
  int cur_m, cur_n, cur_s;

  typedef struct {
    bit is_err;
    int base;
    int slot;
    int when;
  } exp_t;
  exp_t exp_q[$];

  function automatic int tri_num(int k);
    return k * (k + 1) / 2;
  endfunction

  function automatic int base_of(int m, int n, int s);
    return (SLOTS * (tri_num(m - 1) * tri_num(MAX_DIM) + m * tri_num(n - 1)) + s * m * n)
           % (1 << ADDR_W);
  endfunction

  function automatic void model_reset();
    for (int m = 1; m <= MAX_DIM; m++)
      for (int n = 1; n <= MAX_DIM; n++) begin
        mptr[m][n] = 0;
        for (int s = 0; s < SLOTS; s++) mvalid[m][n][s] = 1'b0;
      end
    in_busy = 1'b0;
  endfunction

  function automatic void model_commit();
    if (in_busy) begin
      mvalid[cur_m][cur_n][cur_s] = 1'b1;
      mptr[cur_m][cur_n] = (cur_s + 1) % SLOTS;
      in_busy = 1'b0;
    end
  endfunction

  // Monitor: pops an expectation each time the DUT grants or flags an error.
  always @(negedge clk) begin
    if (alloc_ready || alloc_err) begin
      check("ready_err_exclusive", 32'(alloc_ready & alloc_err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(alloc_ready), 0);
        check("unexpected_err", 32'(alloc_err), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_is_err", 32'(alloc_err), 32'(e.is_err));
        check("out_cycle", cyc, e.when);
        if (!e.is_err) begin
          check("grant_base", 32'(alloc_base), e.base);
          check("grant_slot", 32'(alloc_slot), e.slot);
        end
      end
    end
  end

  task automatic do_alloc(input int m, input int n);
    int s;
    @(negedge clk);
    alloc_req = 1'b1;
    alloc_m   = 32'(m);
    alloc_n   = 32'(n);
    model_commit();
    s = mptr[m][n];
    for (int i = SLOTS - 1; i >= 0; i--) if (!mvalid[m][n][i]) s = i;
    mvalid[m][n][s] = 1'b0;
    in_busy = 1'b1;
    cur_m = m;
    cur_n = n;
    cur_s = s;
    exp_q.push_back('{is_err: 1'b0, base: base_of(m, n, s), slot: s, when: cyc + 2});
    @(negedge clk);
    alloc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_grant", 32'(busy), 1);
  endtask

  task automatic do_bad(input logic [31:0] m, input logic [31:0] n, input int hold);
    @(negedge clk);
    alloc_req = 1'b1;
    alloc_m   = m;
    alloc_n   = n;
    model_commit();
    exp_q.push_back('{is_err: 1'b1, base: 0, slot: 0, when: cyc + 1});
    repeat (hold) @(negedge clk);
    alloc_req = 1'b0;
    @(negedge clk);
    check("busy_after_err", 32'(busy), 0);
  endtask

  task automatic do_end(input bit c, input bit a);
    @(negedge clk);
    commit = c;
    abort  = a;
    if (in_busy) begin
      if (a) in_busy = 1'b0;
      else if (c) model_commit();
    end
    @(negedge clk);
    commit = 1'b0;
    abort  = 1'b0;
    check("busy_after_end", 32'(busy), 32'(in_busy));
  endtask

  task automatic do_query(input int qm, input int qn, input int qs);
    bit ok;
    int cnt;
    @(negedge clk);
    q_m    = 3'(qm);
    q_n    = 3'(qn);
    q_slot = SLOT_W'(qs);
    @(negedge clk);
    ok = (qm >= 1) && (qm <= MAX_DIM) && (qn >= 1) && (qn <= MAX_DIM) && (qs < SLOTS);
    cnt = 0;
    if (ok) for (int s = 0; s < SLOTS; s++) cnt += int'(mvalid[qm][qn][s]);
    check($sformatf("q_valid(%0d,%0d,%0d)", qm, qn, qs), 32'(q_valid),
          ok ? 32'(mvalid[qm][qn][qs]) : 0);
    check($sformatf("q_count(%0d,%0d)", qm, qn), 32'(q_count), cnt);
    check($sformatf("q_base(%0d,%0d,%0d)", qm, qn, qs), 32'(q_base),
          ok ? base_of(qm, qn, qs) : 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(alloc_ready), 0);
    check("rst_err", 32'(alloc_err), 0);
    check("rst_base", 32'(alloc_base), 0);
    check("rst_slot", 32'(alloc_slot), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_q_count", 32'(q_count), 0);
    check("rst_q_base", 32'(q_base), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; alloc_req = 1'b0; commit = 1'b0; abort = 1'b0;
    alloc_m = '0; alloc_n = '0; q_m = 3'd2; q_n = 3'd3; q_slot = '0;
    model_reset();
    do_reset(3);

    // 2x3 allocation, commit, then query.
    do_alloc(2, 3);
    check("base_2x3_s0", 32'(alloc_base), 42);
    do_end(1'b1, 1'b0);
    do_query(2, 3, 0);
    do_alloc(2, 3);
    check("base_2x3_s1", 32'(alloc_base), 48);
    do_end(1'b1, 1'b0);
    do_alloc(2, 3);
    check("base_2x3_oldest", 32'(alloc_base), 42);
    do_query(2, 3, 0);
    do_end(1'b1, 1'b0);
    do_query(2, 3, 1);

    // Class extremes.
    do_alloc(5, 5);
    check("base_5x5_s0", 32'(alloc_base), 400);
    do_end(1'b1, 1'b0);
    do_alloc(5, 5);
    check("base_5x5_s1", 32'(alloc_base), 425);
    do_end(1'b1, 1'b0);
    do_alloc(1, 1);
    check("base_1x1", 32'(alloc_base), 0);
    do_end(1'b1, 1'b0);

    // Illegal dims held three cycles: one pulse, no grant.
    do_bad(32'd6, 32'd1, 3);
    do_alloc(1, 2);
    do_end(1'b1, 1'b0);

    // commit+abort resolves as abort; request in BUSY commits implicitly.
    do_alloc(3, 3);
    do_end(1'b1, 1'b1);
    do_query(3, 3, 0);
    do_alloc(3, 3);
    do_alloc(3, 5);
    check("base_3x5", 32'(alloc_base), 150);
    do_query(3, 3, 0);
    do_end(1'b1, 1'b0);

    // Illegal dims while BUSY, and commit/abort outside BUSY.
    do_alloc(4, 2);
    do_bad(32'h8000_0003, 32'd2, 1);
    do_query(4, 2, 0);
    do_end(1'b1, 1'b0);
    do_end(1'b0, 1'b1);

    // Reset mid-BUSY.
    do_alloc(2, 3);
    do_reset(2);
    for (int m = 1; m <= MAX_DIM; m++)
      for (int n = 1; n <= MAX_DIM; n++) do_query(m, n, 0);
    do_query(2, 3, 1);
    do_alloc(2, 3);
    check("base_after_reset", 32'(alloc_base), 42);
    do_end(1'b1, 1'b0);

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        do_alloc(int'($urandom_range(1, MAX_DIM)), int'($urandom_range(1, MAX_DIM)));
      end else if (op == 4) begin
        logic [31:0] bad, good;
        case ($urandom_range(0, 2))
          0: bad = 32'd0;
          1: bad = 32'($urandom_range(MAX_DIM + 1, 40));
          default: bad = $urandom | 32'h100;
        endcase
        good = 32'($urandom_range(1, MAX_DIM));
        if ($urandom_range(0, 1) == 0) do_bad(bad, good, int'($urandom_range(1, 3)));
        else do_bad(good, bad, int'($urandom_range(1, 3)));
      end else if (op <= 6) begin
        do_end(1'b1, 1'b0);
      end else if (op == 7) begin
        do_end(1'b0, 1'b1);
      end else if (op == 8) begin
        do_end(1'b1, 1'b1);
      end else begin
        do_query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, SLOTS - 1)));
      end
      if (it % 3 == 0)
        do_query(int'($urandom_range(1, MAX_DIM)), int'($urandom_range(1, MAX_DIM)),
                 int'($urandom_range(0, SLOTS - 1)));
    end

    do_end(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
